// File: rtl/spi_slave_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_reg_ctrl
//
// Command decoder between the SPI receive shifter and the configuration
// register file. The first byte of each chip-select frame is an opcode:
//   000100aa : WRITE starting at register aa. Every following byte in the
//              frame is written, and the address wraps 3 -> 0 (burst).
//   001000aa : READ register aa. After dummy_cycles idle cycles the register
//              value is handed to the transmit shifter.
//   others   : unknown. cmd_err pulses and the rest of the frame is ignored.
// Everything runs in the sclk domain and every output is registered.
//
// Ports
//   sclk          SPI clock; all state changes on its rising edge
//   rstn          synchronous active-low reset
//   frame_start   one-cycle pulse in the first cycle of a chip-select frame
//   rx_data       received byte, qualified by rx_valid
//   rx_valid      one-cycle pulse per complete received byte
//   wr_data       register write data
//   wr_addr       register write address
//   wr_data_valid one-cycle register write strobe
//   rd_addr       register read address
//   rd_data       combinational read data from the register file
//   dummy_cycles  dummy cycles inserted before the read data
//   tx_data       byte handed to the transmit shifter
//   tx_load       one-cycle pulse; tx_data is valid
//   cmd_err       one-cycle pulse on an unknown opcode
// -----------------------------------------------------------------------------
module spi_slave_reg_ctrl #(
  parameter int REG_SIZE = 8
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                frame_start,
  input  logic [REG_SIZE-1:0] rx_data,
  input  logic                rx_valid,
  output logic [REG_SIZE-1:0] wr_data,
  output logic [1:0]          wr_addr,
  output logic                wr_data_valid,
  output logic [1:0]          rd_addr,
  input  logic [REG_SIZE-1:0] rd_data,
  input  logic [7:0]          dummy_cycles,
  output logic [REG_SIZE-1:0] tx_data,
  output logic                tx_load,
  output logic                cmd_err
);

  localparam logic [1:0] CMD   = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] DUMMY = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] OP_WRITE = 6'b000100;
  localparam logic [5:0] OP_READ  = 6'b001000;

  logic [1:0] state;
  logic [1:0] cur_state;
  logic [1:0] waddr;
  logic [7:0] cnt;

  // frame_start overrides whatever state the previous frame left behind, so a
  // byte arriving together with frame_start is decoded as the new opcode and
  // an unfinished read is dropped.
  assign cur_state = frame_start ? CMD : state;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples the values from before the edge, whatever the order of
  // the statements below.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state         <= CMD;
      waddr         <= '0;
      cnt           <= '0;
      wr_data       <= '0;
      wr_addr       <= '0;
      wr_data_valid <= 1'b0;
      rd_addr       <= '0;
      tx_data       <= '0;
      tx_load       <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      // Pulse outputs are low unless a branch below raises them.
      wr_data_valid <= 1'b0;
      tx_load       <= 1'b0;
      cmd_err       <= 1'b0;

      if (frame_start) begin
        state <= CMD;
        cnt   <= '0;
      end

      case (cur_state)
        CMD: begin
          if (rx_valid) begin
            if (rx_data[7:2] == OP_WRITE) begin
              waddr <= rx_data[1:0];
              state <= WDATA;
            end else if (rx_data[7:2] == OP_READ) begin
              rd_addr <= rx_data[1:0];
              // Sampled once here; later changes do not affect this read.
              cnt     <= dummy_cycles;
              state   <= DUMMY;
            end else begin
              cmd_err <= 1'b1;
              state   <= DONE;
            end
          end
        end

        WDATA: begin
          if (rx_valid) begin
            wr_data       <= rx_data;
            wr_addr       <= waddr;
            wr_data_valid <= 1'b1;
            waddr         <= waddr + 2'd1;  // 2-bit wrap 3 -> 0
          end
        end

        DUMMY: begin
          if (cnt == 8'd0) begin
            tx_data <= rd_data;
            tx_load <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          // DONE: the remainder of the frame is ignored.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_reg_ctrl
//
// Directed stimulus for spi_slave_reg_ctrl. The stimulus process pushes the
// expected write strobes, tx loads and command errors (with the cycle in
// which each must appear) into queues; a monitor on the falling edge pops and
// compares whenever the DUT raises one of its pulse outputs. A pulse with no
// matching expectation is an error, as is an expectation left over at the end.
// -----------------------------------------------------------------------------
module tb_spi_slave_reg_ctrl;

  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       sclk = 1'b0;
  logic       rstn;
  logic       frame_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] wr_data;
  logic [1:0] wr_addr;
  logic       wr_data_valid;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dummy_cycles;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       cmd_err;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t wq[$];
  exp_t tq[$];
  exp_t eq[$];

  spi_slave_reg_ctrl #(.REG_SIZE(8)) dut (
    .sclk          (sclk),
    .rstn          (rstn),
    .frame_start   (frame_start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .wr_data       (wr_data),
    .wr_addr       (wr_addr),
    .wr_data_valid (wr_data_valid),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .dummy_cycles  (dummy_cycles),
    .tx_data       (tx_data),
    .tx_load       (tx_load),
    .cmd_err       (cmd_err)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: pulse seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge sclk) begin
    exp_t e;
    if (wr_data_valid === 1'b1) begin
      if (wq.size() == 0) unexpected("wr_strobe");
      else begin
        e = wq.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
    if (tx_load === 1'b1) begin
      if (tq.size() == 0) unexpected("tx_load");
      else begin
        e = tq.pop_front();
        check("tx_cycle", cyc, e.cyc);
        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
      end
    end
    if (cmd_err === 1'b1) begin
      if (eq.size() == 0) unexpected("cmd_err");
      else begin
        e = eq.pop_front();
        check("err_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one byte in the cycle following the next rising edge.
  task automatic send(input logic [7:0] b, input logic fs);
    @(posedge sclk);
    #1;
    rx_data     = b;
    rx_valid    = 1'b1;
    frame_start = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
      rx_valid    = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic push_wr(input int c, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_tx(input int c, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.addr = 2'd0; e.data = d;
    tq.push_back(e);
  endtask

  task automatic push_err(input int c);
    exp_t e;
    e.cyc = c; e.addr = 2'd0; e.data = 8'd0;
    eq.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outputs"},
          {wr_data, tx_data, 4'd0, wr_addr, rd_addr, 5'd0, wr_data_valid, tx_load, cmd_err},
          32'd0);
  endtask

  initial begin
    rstn         = 1'b0;
    frame_start  = 1'b0;
    rx_data      = 8'd0;
    rx_valid     = 1'b0;
    rd_data      = 8'h5C;
    dummy_cycles = 8'd32;
    idle(3);
    rstn = 1'b1;
    check_all_zero("reset");

    // Single write: reg1 <= 0x08, strobe one cycle after the data byte.
    send(8'h11, 1'b1);
    send(8'h08, 1'b0); push_wr(cyc + 1, 2'd1, 8'h08);
    idle(3);

    // Burst write with address wrap 2, 3, 0 (back-to-back bytes).
    send(8'h12, 1'b1);
    send(8'hA0, 1'b0); push_wr(cyc + 1, 2'd2, 8'hA0);
    send(8'hA1, 1'b0); push_wr(cyc + 1, 2'd3, 8'hA1);
    send(8'hA2, 1'b0); push_wr(cyc + 1, 2'd0, 8'hA2);
    idle(3);

    // Read reg1 with 32 dummy cycles; dummy_cycles changes mid-read.
    send(8'h21, 1'b1); push_tx(cyc + 34, 8'h5C);
    idle(1);
    dummy_cycles = 8'd3;
    idle(40);
    check("rd_addr_r1", {30'd0, rd_addr}, 32'd1);

    // Read reg2 with zero dummy cycles.
    dummy_cycles = 8'd0;
    rd_data      = 8'h3E;
    send(8'h22, 1'b1); push_tx(cyc + 2, 8'h3E);
    idle(4);
    check("rd_addr_r2", {30'd0, rd_addr}, 32'd2);

    // Read reg3 aborted by frame_start 5 cycles into a 32-cycle wait.
    dummy_cycles = 8'd32;
    rd_data      = 8'h99;
    send(8'h23, 1'b1);
    idle(4);
    @(posedge sclk); #1; frame_start = 1'b1;
    idle(40);
    check("rd_addr_abort", {30'd0, rd_addr}, 32'd3);
    check("tx_data_kept", {24'd0, tx_data}, 32'h3E);

    // Next opcode decodes normally: read reg0 with 255 dummy cycles.
    dummy_cycles = 8'd255;
    rd_data      = 8'hC3;
    send(8'h20, 1'b1); push_tx(cyc + 257, 8'hC3);
    idle(260);
    check("rd_addr_r0", {30'd0, rd_addr}, 32'd0);

    // Unknown opcode, then the rest of the frame is ignored.
    send(8'hFF, 1'b1); push_err(cyc + 1);
    send(8'h11, 1'b0);
    send(8'h44, 1'b0);
    idle(4);

    // Reset in the middle of a write burst, with a data byte in the reset cycle.
    send(8'h12, 1'b1);
    send(8'h33, 1'b0); push_wr(cyc + 1, 2'd2, 8'h33);
    idle(2);
    @(posedge sclk); #1;
    rstn     = 1'b0;
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    @(posedge sclk); #1;
    rstn     = 1'b1;
    rx_valid = 1'b0;
    check_all_zero("mid_reset");
    idle(2);
    send(8'h10, 1'b1);
    send(8'h01, 1'b0); push_wr(cyc + 1, 2'd0, 8'h01);
    idle(4);

    check("wr_left", wq.size(), 32'd0);
    check("tx_left", tq.size(), 32'd0);
    check("err_left", eq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_reg_ctrl.md
Name: spi_slave_reg_ctrl

Overview:
- Command decoder directly upstream of the SPI slave configuration register file.
- Consumes complete bytes from the SPI receive shifter and decodes register read and write opcodes.
- Drives the register file's write port and read address.
- Counts the configured dummy cycles before handing the read value to the transmit shifter.
- Runs entirely in the sclk domain.

Parameters:
REG_SIZE, 8, width of the register data path, rx_data, tx_data, wr_data and rd_data.

Ports:
sclk  input  1  SPI clock; all state updates on posedge.
rstn  input  1  synchronous active-low reset, sampled on posedge sclk.
frame_start  input  1  one-cycle pulse in the first cycle of a new chip-select frame.
rx_data  input  REG_SIZE  received byte; valid when rx_valid is high.
rx_valid  input  1  one-cycle pulse per complete received byte.
wr_data  output  REG_SIZE  register write data.
wr_addr  output  2  register write address.
wr_data_valid  output  1  one-cycle register write strobe.
rd_addr  output  2  register read address.
rd_data  input  REG_SIZE  combinational read data from the register file.
dummy_cycles  input  8  dummy cycles to insert before read data.
tx_data  output  REG_SIZE  byte handed to the transmit shifter.
tx_load  output  1  one-cycle pulse; tx_data is valid.
cmd_err  output  1  one-cycle pulse when an unknown opcode is received.

Behaviour:
- Clock and reset: one clock, sclk; reset rstn is synchronous, active-low.
- Reset values: all outputs 0; wr_addr = 0, rd_addr = 0; state = CMD; cnt = 0.
- Reset applies at the next posedge regardless of state. A reset in the middle of a frame aborts it with no write strobe and no tx_load.
- All outputs are registered.

Opcodes (first byte of a frame), with aa = opcode[1:0]:
- opcode[7:2] = 6'b000100: WRITE reg aa.
- opcode[7:2] = 6'b001000: READ reg aa.
- Any other value is unknown.

States:
- CMD: waits for rx_valid.
  - WRITE: waddr <= aa; go to WDATA.
  - READ: rd_addr <= aa; cnt <= dummy_cycles (sampled in the same cycle); go to DUMMY.
  - Unknown: cmd_err <= 1 for one cycle; go to DONE.
- WDATA: on each rx_valid: wr_data <= rx_data, wr_addr <= waddr, wr_data_valid <= 1 for one cycle, waddr <= waddr + 1.
  - waddr is 2 bits and wraps 3 -> 0.
  - Remains in WDATA (burst write) until frame_start or reset.
- DUMMY: each cycle:
  - If cnt == 0: tx_data <= rd_data, tx_load <= 1, go to DONE.
  - Otherwise cnt <= cnt - 1.
  - rx_valid is ignored.
- DONE: ignores rx_valid until frame_start.

Read latency:
- READ opcode with rx_valid in cycle T and dummy_cycles = N: tx_load is high in cycle T+2+N.
- With N = 0, tx_load is high in T+2. With N = 255, in T+257.
- A change of dummy_cycles after cycle T does not affect the read in progress.

Write latency:
- wr_data_valid is high in the cycle after the data byte's rx_valid.

frame_start:
- In any state it forces the state to CMD and clears any pending dummy count; no tx_load is issued for an aborted read.
- If rx_valid coincides with frame_start, that byte is decoded as the opcode of the new frame.
- frame_start does not clear rd_addr or tx_data.

Outputs outside their pulse cycles:
- wr_data_valid, tx_load and cmd_err are low except in their single-cycle pulses.
- wr_data, wr_addr, rd_addr and tx_data hold their last values.

rx_valid timing:
- Back-to-back rx_valid in consecutive cycles is legal in WDATA; each one produces its own strobe.

Test Plan:
- Reset, then frame_start + 0x11 (write reg1) then 0x08 -> wr_data_valid pulse one cycle after the data byte, wr_addr = 1, wr_data = 0x08; no cmd_err.
- Burst: 0x12 then 0xA0, 0xA1, 0xA2 -> three strobes with wr_addr 2, 3, 0 and data 0xA0, 0xA1, 0xA2 (wrap-around).
- Read: 0x21 with dummy_cycles = 32, rd_data = 0x5C -> rd_addr = 1; tx_load high exactly 34 cycles after the opcode's rx_valid cycle, tx_data = 0x5C.
- Read with dummy_cycles = 0; the same read with frame_start asserted 5 cycles into a 32-cycle dummy wait -> first case: tx_load in T+2. Second case: no tx_load; state CMD, and the next opcode decodes normally.
- Opcode 0xFF -> cmd_err for one cycle; the following bytes 0x11, 0x44 in the same frame produce no wr_data_valid.
- rstn low for one cycle during WDATA, followed by a data byte -> no strobe; all outputs 0; after release, frame_start + 0x10, 0x01 writes reg0 = 0x01.
